// File: rtl/addsub_sequencer.sv
// Control FSM sequencing an accumulator datapath through A +/- B +/- C +/- D.
// Optional operand bypass is enabled by defining ADDSUB_SEQ_SKIP_EN.
module addsub_sequencer #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] ops,
`ifdef ADDSUB_SEQ_SKIP_EN
    input  logic [2:0] skip,
`endif
    input  logic       abort,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       addOrSub,
    output logic       done,
    output logic       busy,
    output logic [2:0] step
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StOpB  = 3'd2,
        StOpC  = 3'd3,
        StOpD  = 3'd4,
        StFin  = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [2:0] ops_q;
    logic [2:0] skip_q;
    logic       hold_done;
    logic       accept;

    logic       s0_q, s0_d;
    logic [1:0] sel_q, sel_d;
    logic       aos_q, aos_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic [2:0] step_q;

    assign accept    = (state_q == StIdle) && start;
    assign hold_done = (hold_q == 4'(HOLD_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            hold_q  <= 4'd0;
            ops_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (accept) ops_q <= ops;
        end
    end

`ifdef ADDSUB_SEQ_SKIP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       skip_q <= 3'b000;
        else if (accept) skip_q <= skip;
    end
`else
    assign skip_q = 3'b000;
`endif

    // Skipped operand states are jumped over, so they consume no cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StLoad;
            StLoad: begin
                if (abort)          state_d = StIdle;
                else if (hold_done) state_d = !skip_q[0] ? StOpB :
                                              !skip_q[1] ? StOpC :
                                              !skip_q[2] ? StOpD : StFin;
            end
            StOpB: begin
                if (abort)          state_d = StIdle;
                else if (hold_done) state_d = !skip_q[1] ? StOpC :
                                              !skip_q[2] ? StOpD : StFin;
            end
            StOpC: begin
                if (abort)          state_d = StIdle;
                else if (hold_done) state_d = !skip_q[2] ? StOpD : StFin;
            end
            StOpD: begin
                if (abort)          state_d = StIdle;
                else if (hold_done) state_d = StFin;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d != state_q)                         hold_d = 4'd0;
        else if (state_q >= StLoad && state_q <= StOpD) hold_d = hold_q + 4'd1;
        else                                            hold_d = 4'd0;
    end

    // Outputs are decoded from the next state so the registered copies line up with step.
    always_comb begin
        s0_d   = s0_q;
        sel_d  = sel_q;
        aos_d  = aos_q;
        done_d = done_q;
        busy_d = 1'b0;
        case (state_d)
            StIdle: done_d = done_q;
            StLoad: begin
                s0_d   = 1'b0;
                sel_d  = 2'b00;
                done_d = 1'b0;
                busy_d = 1'b1;
            end
            StOpB: begin
                s0_d   = 1'b1;
                sel_d  = 2'b00;
                aos_d  = ops_q[0];
                done_d = 1'b0;
                busy_d = 1'b1;
            end
            StOpC: begin
                s0_d   = 1'b1;
                sel_d  = 2'b01;
                aos_d  = ops_q[1];
                done_d = 1'b0;
                busy_d = 1'b1;
            end
            StOpD: begin
                s0_d   = 1'b1;
                sel_d  = 2'b10;
                aos_d  = ops_q[2];
                done_d = 1'b0;
                busy_d = 1'b1;
            end
            StFin:   done_d = 1'b1;
            default: done_d = done_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_q   <= 1'b0;
            sel_q  <= 2'b00;
            aos_q  <= 1'b1;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            step_q <= 3'd0;
        end else begin
            s0_q   <= s0_d;
            sel_q  <= sel_d;
            aos_q  <= aos_d;
            done_q <= done_d;
            busy_q <= busy_d;
            step_q <= state_d;
        end
    end

    assign s0       = s0_q;
    assign s1       = sel_q[0];
    assign s2       = sel_q[1];
    assign addOrSub = aos_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign step     = step_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Bench for addsub_sequencer: two instances (HOLD_CYCLES 1 and 3) against a trace model,
// plus an accumulator datapath on the HOLD_CYCLES=1 instance.
module tb_addsub_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_v [2];
    logic [2:0] ops_v   [2];
    logic [2:0] skip_v  [2];
    logic       abort_v [2];
    logic       s0_v    [2];
    logic       s1_v    [2];
    logic       s2_v    [2];
    logic       aos_v   [2];
    logic       done_v  [2];
    logic       busy_v  [2];
    logic [2:0] step_v  [2];

    int checks   = 0;
    int failures = 0;

    // Model of the last driven values per instance.
    logic       m_s0   [2];
    logic [1:0] m_sel  [2];
    logic       m_aos  [2];
    logic       m_done [2];

    int da, db, dc, dd;
    int acc;
    int opnd;

    always #5 clock = ~clock;

    addsub_sequencer #(.HOLD_CYCLES(1)) dut0 (
        .clock    (clock),
        .reset    (reset),
        .start    (start_v[0]),
        .ops      (ops_v[0]),
`ifdef ADDSUB_SEQ_SKIP_EN
        .skip     (skip_v[0]),
`endif
        .abort    (abort_v[0]),
        .s0       (s0_v[0]),
        .s1       (s1_v[0]),
        .s2       (s2_v[0]),
        .addOrSub (aos_v[0]),
        .done     (done_v[0]),
        .busy     (busy_v[0]),
        .step     (step_v[0])
    );

    addsub_sequencer #(.HOLD_CYCLES(3)) dut1 (
        .clock    (clock),
        .reset    (reset),
        .start    (start_v[1]),
        .ops      (ops_v[1]),
`ifdef ADDSUB_SEQ_SKIP_EN
        .skip     (skip_v[1]),
`endif
        .abort    (abort_v[1]),
        .s0       (s0_v[1]),
        .s1       (s1_v[1]),
        .s2       (s2_v[1]),
        .addOrSub (aos_v[1]),
        .done     (done_v[1]),
        .busy     (busy_v[1]),
        .step     (step_v[1])
    );

    always_comb begin
        case ({s2_v[0], s1_v[0]})
            2'b00:   opnd = db;
            2'b01:   opnd = dc;
            default: opnd = dd;
        endcase
    end

    always @(posedge clock or posedge reset) begin
        if (reset) acc <= 0;
        else if (!done_v[0]) acc <= !s0_v[0] ? da : (aos_v[0] ? acc + opnd : acc - opnd);
    end

    task automatic chk(input string tag, input int u, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s unit%0d got=%0d exp=%0d", tag, u, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_s0[u]   = 1'b0;
            m_sel[u]  = 2'b00;
            m_aos[u]  = 1'b1;
            m_done[u] = 1'b0;
        end
    endtask

    task automatic expect_outputs(input int u, input int st);
        chk("step", u, 32'(step_v[u]), st);
        chk("busy", u, 32'(busy_v[u]), (st >= 1 && st <= 4) ? 1 : 0);
        chk("done", u, 32'(done_v[u]), 32'(m_done[u]));
        chk("s0", u, 32'(s0_v[u]), 32'(m_s0[u]));
        chk("sel", u, 32'({s2_v[u], s1_v[u]}), 32'(m_sel[u]));
        chk("addOrSub", u, 32'(aos_v[u]), 32'(m_aos[u]));
    endtask

    // Runs one sequence from IDLE; abort_at is the trace index at which abort is raised.
    task automatic run(input int u, input logic [2:0] op, input logic [2:0] sk,
                       input int abort_at);
        int q[$];
        int h;
        int exp_acc;
        int st;
        int terms[3];
        h = (u == 0) ? 1 : 3;
        terms[0] = db;
        terms[1] = dc;
        terms[2] = dd;
        exp_acc = da;
        repeat (h) q.push_back(1);
        for (int i = 0; i < 3; i++) begin
            if (!sk[i]) begin
                repeat (h) q.push_back(2 + i);
                exp_acc = op[i] ? exp_acc + terms[i] : exp_acc - terms[i];
            end
        end
        q.push_back(5);
        q.push_back(0);

        start_v[u] = 1'b1;
        ops_v[u]   = op;
        skip_v[u]  = sk;
        abort_v[u] = 1'($urandom % 2);
        @(posedge clock); #1;
        for (int k = 0; k < q.size(); k++) begin
            st = q[k];
            if (st >= 1 && st <= 4) begin
                m_done[u] = 1'b0;
                if (st == 1) begin
                    m_s0[u]  = 1'b0;
                    m_sel[u] = 2'b00;
                end else begin
                    m_s0[u]  = 1'b1;
                    m_sel[u] = 2'(st - 2);
                    m_aos[u] = op[st - 2];
                end
            end else if (st == 5) begin
                m_done[u] = 1'b1;
            end
            expect_outputs(u, st);
            if (st == 5 && u == 0 && abort_at < 0) chk("acc", u, acc, exp_acc);
            if (k == abort_at) begin
                abort_v[u] = 1'b1;
                start_v[u] = 1'($urandom % 2);
                ops_v[u]   = 3'($urandom);
                @(posedge clock); #1;
                abort_v[u] = 1'b0;
                start_v[u] = 1'b0;
                m_done[u]  = 1'b0;
                expect_outputs(u, 0);
                return;
            end
            if (k == q.size() - 1) begin
                start_v[u] = 1'b0;
                abort_v[u] = 1'b0;
            end else begin
                start_v[u] = 1'($urandom % 2);
                abort_v[u] = (st == 5) ? 1'($urandom % 2) : 1'b0;
                ops_v[u]   = 3'($urandom);
                skip_v[u]  = 3'($urandom);
                @(posedge clock); #1;
            end
        end
    endtask

    initial begin
        int u, nb, ab;
        logic [2:0] op, sk;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            ops_v[i]   = 3'b000;
            skip_v[i]  = 3'b000;
            abort_v[i] = 1'b0;
        end
        da = 7; db = 2; dc = 5; dd = 1;
        model_reset();
        #1 reset = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) expect_outputs(i, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        run(0, 3'b101, 3'b000, -1);
        run(1, 3'b000, 3'b000, -1);
        run(0, 3'b110, 3'b000, 2);
        run(0, 3'b010, 3'b000, -1);
        da = 10; db = 3; dc = 4; dd = 20;
        run(0, 3'b011, 3'b000, -1);
        run(1, 3'b111, 3'b000, 5);

        // Asynchronous reset in the middle of OP_B on the slow instance.
        start_v[1] = 1'b1;
        ops_v[1]   = 3'b111;
        @(posedge clock); #1;
        repeat (3) @(posedge clock);
        #1;
        chk("step_pre_reset", 1, 32'(step_v[1]), 2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) expect_outputs(i, 0);
        reset = 1'b0;
        run(1, 3'b100, 3'b000, -1);

`ifdef ADDSUB_SEQ_SKIP_EN
        run(0, 3'b001, 3'b010, -1);
        run(0, 3'b110, 3'b111, -1);
        run(1, 3'b011, 3'b101, -1);
`endif

        for (int it = 0; it < 24; it++) begin
            u  = int'($urandom % 2);
            op = 3'($urandom);
`ifdef ADDSUB_SEQ_SKIP_EN
            sk = 3'($urandom);
`else
            sk = 3'b000;
`endif
            da = int'($urandom % 200) - 100;
            db = int'($urandom % 200) - 100;
            dc = int'($urandom % 200) - 100;
            dd = int'($urandom % 200) - 100;
            nb = ((u == 0) ? 1 : 3) * (1 + (sk[0] ? 0 : 1) + (sk[1] ? 0 : 1) + (sk[2] ? 0 : 1));
            ab = ($urandom % 4 == 0) ? int'($urandom % nb) : -1;
            run(u, op, sk, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
